// File: rtl/memcpy_pkg.sv
// Shared definitions for the memcpy sequencer slice.
//   state_e    : sequencer FSM states
//   ls_type_e  : load/store width encodings, identical to the main decoder's
//   ctrl_t     : the control fields the sequencer overrides while active
//   ls_for     : picks the transfer width from the bytes still to copy
//   step_bytes : byte advance that goes with a transfer width
package memcpy_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_SKIP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } ls_type_e;

  typedef struct packed {
    logic memcpy_store;
    logic mem_read;
    logic mem_write;
    logic write_en;
    logic counter_sel;
    logic stay;
    logic done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  localparam ctrl_t CTRL_LOAD = '{
    memcpy_store: 1'b0, mem_read: 1'b1, mem_write: 1'b0, write_en: 1'b1,
    counter_sel:  1'b1, stay:     1'b1, done:      1'b0
  };

  localparam ctrl_t CTRL_SKIP = '{
    memcpy_store: 1'b0, mem_read: 1'b0, mem_write: 1'b0, write_en: 1'b0,
    counter_sel:  1'b0, stay:     1'b0, done:      1'b1
  };

  // The final store releases the PC and signals completion in the same cycle.
  function automatic ctrl_t store_ctrl(input logic last);
    ctrl_t c;
    c = '{
      memcpy_store: 1'b1, mem_read: 1'b0, mem_write: 1'b1, write_en: 1'b0,
      counter_sel:  1'b1, stay:     1'b1, done:      1'b0
    };
    c.stay = ~last;
    c.done = last;
    return c;
  endfunction

  // Word transfers only while a full word remains; a short tail goes bytewise.
  function automatic ls_type_e ls_for(input int unsigned rem, input logic words);
    return (words && rem >= 4) ? LS_WORD : LS_BYTE;
  endfunction

  function automatic int unsigned step_bytes(input ls_type_e ls);
    return (ls == LS_WORD) ? 4 : 1;
  endfunction

endpackage

// File: rtl/memcpy_sequencer_if.sv
// Bus between the decoder stage and the memcpy sequencer.
//   master : decoder side, drives start/len/words, observes the overrides
//   slave  : sequencer side, samples the request, drives busy, strobes,
//            ls_type, offset, stay and done
interface memcpy_sequencer_if #(
  parameter int N_WIDTH   = 7,
  parameter int REG_WIDTH = 32
);
  logic                 start;
  logic [N_WIDTH-1:0]   len;
  logic                 words;
  logic                 busy;
  logic                 memcpy_store;
  logic                 mem_read;
  logic                 mem_write;
  logic                 write_en;
  logic [1:0]           ls_type;
  logic                 counter_sel;
  logic [REG_WIDTH-1:0] offset;
  logic                 stay;
  logic                 done;

  modport master (
    output start, len, words,
    input  busy, memcpy_store, mem_read, mem_write, write_en,
           ls_type, counter_sel, offset, stay, done
  );

  modport slave (
    input  start, len, words,
    output busy, memcpy_store, mem_read, mem_write, write_en,
           ls_type, counter_sel, offset, stay, done
  );
endinterface

// File: rtl/memcpy_offset_counter.sv
// Running byte offset for the memcpy sequencer.
//   clk, rstn   : clock, asynchronous active-low reset
//   clear       : return offset to 0 (end of sequence)
//   advance     : offset <= offset_next (end of a non-final store)
//   len, words  : latched request
//   offset      : current byte offset
//   offset_next : offset plus the step of the current transfer
//   last        : the current transfer reaches or passes len
module memcpy_offset_counter
  import memcpy_pkg::*;
#(
  parameter int N_WIDTH = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               advance,
  input  logic [N_WIDTH-1:0] len,
  input  logic               words,
  output logic [N_WIDTH-1:0] offset,
  output logic [N_WIDTH-1:0] offset_next,
  output logic               last
);

  localparam int SW = N_WIDTH + 1;

  logic [N_WIDTH-1:0] rem;
  ls_type_e           ls;
  logic [SW-1:0]      sum;

  // offset never exceeds len while a transfer is pending, so rem cannot underflow.
  assign rem = len - offset;
  assign ls  = ls_for(32'(rem), words);

  // One extra bit keeps offset+4 from wrapping when len is near its maximum.
  assign sum         = {1'b0, offset} + SW'(step_bytes(ls));
  assign last        = (sum >= {1'b0, len});
  assign offset_next = sum[N_WIDTH-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      offset <= '0;
    end else if (clear) begin
      offset <= '0;
    end else if (advance) begin
      offset <= offset_next;
    end
  end

endmodule

// File: rtl/memcpy_sequencer.sv
// Multi-cycle sequencer for one memcpy instruction. Alternates LOAD and
// STORE cycles over len bytes, supplies the running offset to the ALU and
// holds the PC until the final store, on which done pulses. len==0 takes a
// single SKIP cycle that only pulses done.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : memcpy_sequencer_if.slave (request in, control overrides out)
module memcpy_sequencer
  import memcpy_pkg::*;
#(
  parameter int N_WIDTH   = 7,
  parameter int REG_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rstn,
  memcpy_sequencer_if.slave bus
);

  state_e             state_q;
  logic [N_WIDTH-1:0] len_q;
  logic               words_q;
  ctrl_t              ctrl_q;
  ls_type_e           ls_q;

  logic [N_WIDTH-1:0] offset;
  logic [N_WIDTH-1:0] offset_next;
  logic               last;
  logic               in_store;
  logic [N_WIDTH-1:0] rem_next;

  assign in_store = (state_q == S_STORE);

  memcpy_offset_counter #(.N_WIDTH(N_WIDTH)) u_offset_counter (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (in_store && last),
    .advance     (in_store && !last),
    .len         (len_q),
    .words       (words_q),
    .offset      (offset),
    .offset_next (offset_next),
    .last        (last)
  );

  // Bytes left once the current pair retires; sets the width of the next pair.
  assign rem_next = len_q - offset_next;

  // Outputs are registered on entry to each state so they line up with it.
  // ls_type is chosen from the offset the next pair will use, so it stays
  // fixed across that LOAD/STORE pair.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: every register here uses <= so all of them see the pre-edge
    // values of state_q, offset and last; a blocking = would let later
    // statements observe half-updated state.
    if (!rstn) begin
      // NOTE: len_q/words_q are reset too even though they are reloaded
      // before use; it keeps the counter's combinational outputs defined
      // out of reset at negligible cost.
      state_q <= S_IDLE;
      len_q   <= '0;
      words_q <= 1'b0;
      ctrl_q  <= CTRL_IDLE;
      ls_q    <= LS_BYTE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            len_q   <= bus.len;
            words_q <= bus.words;
            if (bus.len != '0) begin
              state_q <= S_LOAD;
              ctrl_q  <= CTRL_LOAD;
              ls_q    <= ls_for(32'(bus.len), bus.words);
            end else begin
              state_q <= S_SKIP;
              ctrl_q  <= CTRL_SKIP;
              ls_q    <= LS_BYTE;
            end
          end
        end

        S_LOAD: begin
          state_q <= S_STORE;
          ctrl_q  <= store_ctrl(last);
        end

        S_STORE: begin
          if (last) begin
            state_q <= S_IDLE;
            ctrl_q  <= CTRL_IDLE;
            ls_q    <= LS_BYTE;
          end else begin
            state_q <= S_LOAD;
            ctrl_q  <= CTRL_LOAD;
            ls_q    <= ls_for(32'(rem_next), words_q);
          end
        end

        S_SKIP: begin
          state_q <= S_IDLE;
          ctrl_q  <= CTRL_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          ctrl_q  <= CTRL_IDLE;
          ls_q    <= LS_BYTE;
        end
      endcase
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.memcpy_store = ctrl_q.memcpy_store;
  assign bus.mem_read     = ctrl_q.mem_read;
  assign bus.mem_write    = ctrl_q.mem_write;
  assign bus.write_en     = ctrl_q.write_en;
  assign bus.counter_sel  = ctrl_q.counter_sel;
  assign bus.stay         = ctrl_q.stay;
  assign bus.done         = ctrl_q.done;
  assign bus.ls_type      = ls_q;
  assign bus.offset       = REG_WIDTH'(offset);

endmodule

// File: tb/tb_memcpy_sequencer.sv
// Directed bench for memcpy_sequencer. Inputs change 1 time unit after a
// rising edge and outputs are checked there, i.e. once the edge has settled.
module tb_memcpy_sequencer;
  import memcpy_pkg::*;

  localparam int N_WIDTH   = 7;
  localparam int REG_WIDTH = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  memcpy_sequencer_if #(.N_WIDTH(N_WIDTH), .REG_WIDTH(REG_WIDTH)) bus ();

  memcpy_sequencer #(.N_WIDTH(N_WIDTH), .REG_WIDTH(REG_WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // {busy, memcpy_store, mem_read, mem_write, write_en, ls_type, counter_sel, stay, done}
  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.memcpy_store, bus.mem_read, bus.mem_write, bus.write_en,
                bus.ls_type, bus.counter_sel, bus.stay, bus.done});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_ctl"}, outs(), 32'd0);
    check({tag, "_ofs"}, bus.offset, 32'd0);
  endtask

  task automatic check_load(input string tag, input int ofs, input logic [1:0] ls);
    check($sformatf("%s_ld%0d_ctl", tag, ofs), outs(),
          32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ls, 1'b1, 1'b1, 1'b0}));
    check($sformatf("%s_ld%0d_ofs", tag, ofs), bus.offset, 32'(ofs));
  endtask

  task automatic check_store(input string tag, input int ofs, input logic [1:0] ls,
                             input logic last);
    check($sformatf("%s_st%0d_ctl", tag, ofs), outs(),
          32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ls, 1'b1, ~last, last}));
    check($sformatf("%s_st%0d_ofs", tag, ofs), bus.offset, 32'(ofs));
  endtask

  task automatic run_pair(input string tag, input int ofs, input logic [1:0] ls,
                          input logic last);
    check_load(tag, ofs, ls);
    tick();
    check_store(tag, ofs, ls, last);
    tick();
  endtask

  task automatic start_op(input int len, input logic words);
    bus.start = 1'b1;
    bus.len   = N_WIDTH'(len);
    bus.words = words;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    bus.words = 1'b0;

    // Reset state
    tick();
    tick();
    expect_idle("reset");
    rstn = 1'b1;
    tick();
    expect_idle("post_reset");

    // 1: reset asserted during a STORE, then a fresh run
    start_op(10, 1'b1);
    check_load("t1", 0, LS_WORD);
    tick();
    check_store("t1", 0, LS_WORD, 1'b0);
    rstn = 1'b0;
    #1;
    expect_idle("t1_rst_async");
    tick();
    rstn = 1'b1;
    expect_idle("t1_rst_edge");
    tick();
    expect_idle("t1_rst_after");

    // 2: len=3 bytewise
    start_op(3, 1'b0);
    run_pair("t2", 0, LS_BYTE, 1'b0);
    run_pair("t2", 1, LS_BYTE, 1'b0);
    run_pair("t2", 2, LS_BYTE, 1'b1);
    expect_idle("t2_end");

    // 3: len=10 with words: two word pairs then a two-byte tail
    start_op(10, 1'b1);
    run_pair("t3", 0, LS_WORD, 1'b0);
    run_pair("t3", 4, LS_WORD, 1'b0);
    run_pair("t3", 8, LS_BYTE, 1'b0);
    run_pair("t3", 9, LS_BYTE, 1'b1);
    expect_idle("t3_end");

    // 4: len=0 takes one SKIP cycle
    start_op(0, 1'b1);
    check("t4_skip_ctl", outs(),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(LS_BYTE), 1'b0, 1'b0, 1'b1}));
    check("t4_skip_ofs", bus.offset, 32'd0);
    tick();
    expect_idle("t4_end");

    // 5: start re-asserted while busy is ignored
    start_op(8, 1'b1);
    check_load("t5", 0, LS_WORD);
    bus.start = 1'b1;
    bus.len   = N_WIDTH'(3);
    bus.words = 1'b0;
    tick();
    check_store("t5", 0, LS_WORD, 1'b0);
    tick();
    bus.start = 1'b0;
    run_pair("t5", 4, LS_WORD, 1'b1);
    expect_idle("t5_end");
    tick();
    expect_idle("t5_no_second_done");

    // 6: maximum length, 31 word pairs then 3 byte pairs (68 cycles)
    start_op(127, 1'b1);
    for (int i = 0; i < 31; i++) begin
      run_pair("t6", 4 * i, LS_WORD, 1'b0);
    end
    run_pair("t6", 124, LS_BYTE, 1'b0);
    run_pair("t6", 125, LS_BYTE, 1'b0);
    run_pair("t6", 126, LS_BYTE, 1'b1);
    expect_idle("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
